// File: rtl/rst_sequencer_pkg.sv
// Shared constants for the reset sequencer: FSM state codes and the
// lock-loss counter width, plus a saturating increment helper.
package rst_sequencer_pkg;

    localparam int LOSS_CNT_W = 8;

    localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
    localparam logic [1:0] ST_RELEASE   = 2'd1;
    localparam logic [1:0] ST_RUN       = 2'd2;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [LOSS_CNT_W-1:0] sat_inc(input logic [LOSS_CNT_W-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/rst_sequencer_lock_filter.sv
// Lock filter: counts consecutive cycles with every lock flag high and
// flags the sample on which that run reaches FILT_CYCLES.
module lock_filter #(
    parameter int N_LOCK      = 3,
    parameter int FILT_CYCLES = 8
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              clear,
    input  logic [N_LOCK-1:0] lock,
    output logic              filter_ok
);

    localparam int CW = $clog2(FILT_CYCLES + 1);
    localparam logic [CW-1:0] FILT_MAX = CW'(FILT_CYCLES);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          all_locked;

    assign all_locked = &lock;

    // Next run length: any low flag restarts it, otherwise count up and hold at the target.
    always_comb begin
        count_next = count_reg;
        if (!all_locked) begin
            count_next = '0;
        end else if (count_reg != FILT_MAX) begin
            count_next = count_reg + 1'b1;
        end
    end

    // filter_ok marks the sample that completes the run, so the FSM can
    // leave WAIT_LOCK on the very edge the count reaches FILT_CYCLES.
    assign filter_ok = (count_next == FILT_MAX);

    // Run-length register; the FSM abort wipes it alongside the global reset.
    always_ff @(posedge clk) begin
        if (srst || clear) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/rst_sequencer.sv
// Reset sequencer: waits for filtered PLL lock, then releases the channel
// resets one by one, STAGE_DLY cycles apart, and falls back to WAIT_LOCK
// on lock loss or a software request.
module rst_sequencer
    import rst_sequencer_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int N_LOCK      = 3,
    parameter int FILT_CYCLES = 8,
    parameter int STAGE_DLY   = 16
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic [N_LOCK-1:0]     lock_i,
    input  logic                  sw_rst_i,
    output logic [N_CH-1:0]       ch_rst_o,
    output logic                  all_done_o,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt_o,
    output logic [1:0]            state_o
);

    localparam int DW = $clog2(STAGE_DLY + 1);
    localparam int SW = $clog2(N_CH + 1);
    localparam logic [DW-1:0] DLY_LAST   = DW'(STAGE_DLY - 1);
    localparam logic [SW-1:0] STAGE_LAST = SW'(N_CH - 1);

    logic [1:0]            state_reg;
    logic [DW-1:0]         dly_reg;
    logic [SW-1:0]         stage_reg;
    logic [N_CH-1:0]       ch_rst_reg;
    logic                  all_done_reg;
    logic [LOSS_CNT_W-1:0] loss_cnt_reg;

    logic            filter_ok;
    logic            lock_lost;
    logic            in_seq;
    logic            abort;
    logic [N_CH-1:0] stage_mask;

    assign lock_lost = ~&lock_i;
    assign in_seq    = (state_reg == ST_RELEASE) || (state_reg == ST_RUN);
    assign abort     = in_seq && (lock_lost || sw_rst_i);

    lock_filter #(
        .N_LOCK      (N_LOCK),
        .FILT_CYCLES (FILT_CYCLES)
    ) u_lock_filter (
        .clk       (wb_clk_i),
        .srst      (wb_rst_i),
        .clear     (abort),
        .lock      (lock_i),
        .filter_ok (filter_ok)
    );

    // One-hot mask of the channel whose release is due at the current stage.
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_stage_mask
            assign stage_mask[gi] = (stage_reg == SW'(gi));
        end
    endgenerate

    // Sequencer FSM; abort has priority over any pending release step.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg    <= ST_WAIT_LOCK;
            dly_reg      <= '0;
            stage_reg    <= '0;
            ch_rst_reg   <= '1;
            all_done_reg <= 1'b0;
            loss_cnt_reg <= '0;
        end else if (abort) begin
            state_reg    <= ST_WAIT_LOCK;
            dly_reg      <= '0;
            stage_reg    <= '0;
            ch_rst_reg   <= '1;
            all_done_reg <= 1'b0;
            if (lock_lost) begin
                loss_cnt_reg <= sat_inc(loss_cnt_reg);
            end
        end else begin
            case (state_reg)
                ST_WAIT_LOCK: begin
                    ch_rst_reg   <= '1;
                    all_done_reg <= 1'b0;
                    if (filter_ok) begin
                        state_reg <= ST_RELEASE;
                        dly_reg   <= '0;
                        stage_reg <= '0;
                    end
                end
                ST_RELEASE: begin
                    if (dly_reg == DLY_LAST) begin
                        dly_reg    <= '0;
                        ch_rst_reg <= ch_rst_reg & ~stage_mask;
                        stage_reg  <= stage_reg + 1'b1;
                        if (stage_reg == STAGE_LAST) begin
                            state_reg    <= ST_RUN;
                            all_done_reg <= 1'b1;
                        end
                    end else begin
                        dly_reg <= dly_reg + 1'b1;
                    end
                end
                ST_RUN: begin
                    all_done_reg <= 1'b1;
                end
                default: begin
                    state_reg    <= ST_WAIT_LOCK;
                    ch_rst_reg   <= '1;
                    all_done_reg <= 1'b0;
                end
            endcase
        end
    end

    assign ch_rst_o        = ch_rst_reg;
    assign all_done_o      = all_done_reg;
    assign lock_loss_cnt_o = loss_cnt_reg;
    assign state_o         = state_reg;

endmodule

// File: tb/tb_rst_sequencer.sv
// Testbench for rst_sequencer (default parameters): table of directed
// vectors, a lock-loss saturation loop and randomized stimulus, all checked
// against a cycle-age reference model.
module tb_rst_sequencer;

    logic       wb_clk_i = 1'b0;
    logic       wb_rst_i = 1'b1;
    logic [2:0] lock_i   = 3'b000;
    logic       sw_rst_i = 1'b0;
    logic [3:0] ch_rst_o;
    logic       all_done_o;
    logic [7:0] lock_loss_cnt_o;
    logic [1:0] state_o;

    int errors = 0;
    int checks = 0;

    // Reference model: mode 0/1/2, run of locked samples, cycles since RELEASE entry.
    int m_mode   = 0;
    int m_run    = 0;
    int m_age    = 0;
    int m_losses = 0;

    always #5 wb_clk_i = ~wb_clk_i;

    rst_sequencer dut (
        .wb_clk_i        (wb_clk_i),
        .wb_rst_i        (wb_rst_i),
        .lock_i          (lock_i),
        .sw_rst_i        (sw_rst_i),
        .ch_rst_o        (ch_rst_o),
        .all_done_o      (all_done_o),
        .lock_loss_cnt_o (lock_loss_cnt_o),
        .state_o         (state_o)
    );

    typedef struct {
        logic       rst;
        logic [2:0] lock;
        logic       sw;
        int         reps;
        logic [3:0] ch;
        logic       done;
        logic [1:0] st;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] model_ch();
        logic [3:0] v;
        for (int k = 0; k < 4; k++) begin
            v[k] = (m_mode == 0) ? 1'b1 : (m_age < (k + 1) * 16);
        end
        return v;
    endfunction

    task automatic model_update(input logic r, input logic [2:0] l, input logic s);
        if (r) begin
            m_mode = 0; m_run = 0; m_age = 0; m_losses = 0;
        end else if (m_mode == 0) begin
            m_run = (&l) ? m_run + 1 : 0;
            if (m_run >= 8) begin
                m_mode = 1;
                m_age  = 0;
            end
        end else if (!(&l)) begin
            if (m_losses < 255) m_losses++;
            m_mode = 0; m_run = 0;
        end else if (s) begin
            m_mode = 0; m_run = 0;
        end else begin
            if (m_age < 1000) m_age++;
            if (m_age >= 64) m_mode = 2;
        end
    endtask

    // One clock cycle: drive on the falling edge, check #1 after the rising edge.
    task automatic step(input logic r, input logic [2:0] l, input logic s);
        logic [7:0] lc;
        @(negedge wb_clk_i);
        wb_rst_i = r;
        lock_i   = l;
        sw_rst_i = s;
        @(posedge wb_clk_i);
        model_update(r, l, s);
        #1;
        lc = 8'(m_losses);
        check("model", {17'd0, ch_rst_o, all_done_o, state_o, lock_loss_cnt_o},
              {17'd0, model_ch(), (m_mode == 2), 2'(m_mode), lc});
    endtask

    task automatic add(input logic r, input logic [2:0] l, input logic s, input int n,
                       input logic [3:0] ch, input logic dn, input logic [1:0] st, input logic [7:0] cnt);
        vec_t v;
        v.rst = r; v.lock = l; v.sw = s; v.reps = n;
        v.ch = ch; v.done = dn; v.st = st; v.cnt = cnt;
        tbl.push_back(v);
    endtask

    initial begin
        // Nominal sequence from reset
        add(1, 3'b111, 0,  2, 4'hF, 0, 2'd0, 8'd0);
        add(0, 3'b111, 0,  7, 4'hF, 0, 2'd0, 8'd0);
        add(0, 3'b111, 0,  1, 4'hF, 0, 2'd1, 8'd0);
        add(0, 3'b111, 0, 15, 4'hF, 0, 2'd1, 8'd0);
        add(0, 3'b111, 0,  1, 4'hE, 0, 2'd1, 8'd0);
        add(0, 3'b111, 0, 16, 4'hC, 0, 2'd1, 8'd0);
        add(0, 3'b111, 0, 16, 4'h8, 0, 2'd1, 8'd0);
        add(0, 3'b111, 0, 15, 4'h8, 0, 2'd1, 8'd0);
        add(0, 3'b111, 0,  1, 4'h0, 1, 2'd2, 8'd0);
        add(0, 3'b111, 0, 10, 4'h0, 1, 2'd2, 8'd0);
        // Lock loss in RUN, then the sequence restarts
        add(0, 3'b110, 0,  1, 4'hF, 0, 2'd0, 8'd1);
        add(0, 3'b111, 0,  7, 4'hF, 0, 2'd0, 8'd1);
        add(0, 3'b111, 0,  1, 4'hF, 0, 2'd1, 8'd1);
        // Software abort 20 cycles into RELEASE
        add(0, 3'b111, 0, 19, 4'hE, 0, 2'd1, 8'd1);
        add(0, 3'b111, 1,  1, 4'hF, 0, 2'd0, 8'd1);
        // sw_rst_i ignored in WAIT_LOCK: the filter keeps counting
        add(0, 3'b111, 1,  7, 4'hF, 0, 2'd0, 8'd1);
        add(0, 3'b111, 0,  1, 4'hF, 0, 2'd1, 8'd1);
        // Software abort coincident with lock loss counts once
        add(0, 3'b111, 0, 19, 4'hE, 0, 2'd1, 8'd1);
        add(0, 3'b011, 1,  1, 4'hF, 0, 2'd0, 8'd2);
        // Filter glitch at 5th sample: no count, filter restarts
        add(0, 3'b111, 0,  4, 4'hF, 0, 2'd0, 8'd2);
        add(0, 3'b101, 0,  1, 4'hF, 0, 2'd0, 8'd2);
        add(0, 3'b111, 0,  7, 4'hF, 0, 2'd0, 8'd2);
        add(0, 3'b111, 0,  1, 4'hF, 0, 2'd1, 8'd2);
        // wb_rst_i mid-RELEASE overrides lock loss and sw_rst_i
        add(0, 3'b111, 0, 30, 4'hE, 0, 2'd1, 8'd2);
        add(1, 3'b000, 1,  1, 4'hF, 0, 2'd0, 8'd0);
        // First sample after reset counts toward the filter
        add(0, 3'b111, 0,  7, 4'hF, 0, 2'd0, 8'd0);
        add(0, 3'b111, 0,  1, 4'hF, 0, 2'd1, 8'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            for (int r = 0; r < tbl[i].reps; r++) begin
                step(tbl[i].rst, tbl[i].lock, tbl[i].sw);
            end
            check($sformatf("vec%0d_ch", i),    32'(ch_rst_o),        32'(tbl[i].ch));
            check($sformatf("vec%0d_done", i),  32'(all_done_o),      32'(tbl[i].done));
            check($sformatf("vec%0d_state", i), 32'(state_o),         32'(tbl[i].st));
            check($sformatf("vec%0d_cnt", i),   32'(lock_loss_cnt_o), 32'(tbl[i].cnt));
            $display("vec %0d: rst=%b lock=%b sw=%b x%0d -> ch=%b done=%b state=%0d cnt=%0d",
                     i, tbl[i].rst, tbl[i].lock, tbl[i].sw, tbl[i].reps,
                     ch_rst_o, all_done_o, state_o, lock_loss_cnt_o);
        end

        // Saturation: 260 lock losses, each from RELEASE
        for (int e = 0; e < 260; e++) begin
            step(0, 3'b110, 0);
            for (int c = 0; c < 8; c++) step(0, 3'b111, 0);
        end
        check("sat_cnt", 32'(lock_loss_cnt_o), 32'd255);
        $display("saturation: 260 loss events -> cnt=%0d", lock_loss_cnt_o);
        step(1, 3'b111, 0);
        check("sat_reset_cnt", 32'(lock_loss_cnt_o), 32'd0);
        $display("reset after saturation -> cnt=%0d state=%0d", lock_loss_cnt_o, state_o);

        // Randomized stimulus against the model
        for (int c = 0; c < 3000; c++) begin
            logic       r;
            logic [2:0] l;
            logic       s;
            r = ($urandom_range(499) == 0);
            l = ($urandom_range(99) == 0) ? 3'($urandom_range(6)) : 3'b111;
            s = ($urandom_range(149) == 0);
            step(r, l, s);
        end
        $display("random: 3000 cycles, final state=%0d cnt=%0d", state_o, lock_loss_cnt_o);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
